// File: rtl/rv2t_instruction_fetch_pkg.sv
// ============================================================================
// Module  : rv2t_instruction_fetch_pkg
// Brief   : Shared fetch-stage state encodings and instruction alignment rules.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rv2t_instruction_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_WAIT  = 2'd2,
        FETCH_FLUSH = 2'd3
    } fetch_state_t;

    // Instructions are word aligned; any set bit under this mask is illegal.
    localparam logic [1:0] c_INSTR_ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & c_INSTR_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv2t_instruction_fetch.sv
// ============================================================================
// Module  : rv2t_instruction_fetch
// Brief   : PC owner and single-outstanding instruction fetcher feeding decode.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rv2t_instruction_fetch
    import rv2t_instruction_fetch_pkg::*;
#(
    parameter int                    PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    input  logic                  fetch_init,
    input  logic [PC_WIDTH-1:0]   start_addr,
    input  logic                  fetch_enable,
    input  logic                  jump_req,
    input  logic [PC_WIDTH-1:0]   jump_addr,
    output logic                  mem_read_req,
    output logic [PC_WIDTH-1:0]   mem_addr,
    input  logic                  mem_read_ack,
    input  logic [31:0]           mem_data,
    output logic                  enable_out,
    output logic [31:0]           IR_out,
    output logic [PC_WIDTH-1:0]   PC_out,
    output logic                  exception_addr_misaligned,
    output logic                  busy
);

    fetch_state_t           r_state,   w_state;
    logic [PC_WIDTH-1:0]    r_pc,      w_pc;
    logic                   r_req,     w_req;
    logic [PC_WIDTH-1:0]    r_addr,    w_addr;
    logic                   r_en,      w_en;
    logic [31:0]            r_ir,      w_ir;
    logic [PC_WIDTH-1:0]    r_pc_out,  w_pc_out;
    logic                   r_exc,     w_exc;

    logic                   w_redirect;
    logic [PC_WIDTH-1:0]    w_target;
    logic                   w_target_bad;
    logic [PC_WIDTH-1:0]    w_pc_inc;

    assign w_redirect   = fetch_init | jump_req;
    assign w_target     = fetch_init ? start_addr : jump_addr;
    assign w_target_bad = is_misaligned(w_target[1:0]);
    assign w_pc_inc     = r_pc + PC_WIDTH'(4);

    always_comb begin
        w_state  = r_state;
        w_pc     = r_pc;
        w_req    = 1'b0;
        w_addr   = r_addr;
        w_en     = 1'b0;
        w_ir     = r_ir;
        w_pc_out = r_pc_out;
        w_exc    = 1'b0;

        case (r_state)
            FETCH_IDLE: begin
                if (fetch_init) begin
                    if (is_misaligned(start_addr[1:0])) begin
                        w_exc = 1'b1;
                    end else begin
                        w_pc    = start_addr;
                        w_state = FETCH_REQ;
                    end
                end
            end

            FETCH_REQ: begin
                if (w_redirect) begin
                    if (w_target_bad) begin
                        w_exc   = 1'b1;
                        w_state = FETCH_IDLE;
                    end else begin
                        w_pc = w_target;
                    end
                end else if (fetch_enable) begin
                    w_req   = 1'b1;
                    w_addr  = r_pc;
                    w_state = FETCH_WAIT;
                end
            end

            FETCH_WAIT: begin
                if (w_redirect) begin
                    if (w_target_bad) begin
                        w_exc   = 1'b1;
                        w_state = FETCH_IDLE;
                    end else begin
                        w_pc    = w_target;
                        w_state = mem_read_ack ? FETCH_REQ : FETCH_FLUSH;
                    end
                end else if (mem_read_ack) begin
                    w_en     = 1'b1;
                    w_ir     = mem_data;
                    w_pc_out = r_pc;
                    w_pc     = w_pc_inc;
                    // Issue the next read straight from the ack cycle so that
                    // enable_out and the following request appear together.
                    if (fetch_enable) begin
                        w_req   = 1'b1;
                        w_addr  = w_pc_inc;
                        w_state = FETCH_WAIT;
                    end else begin
                        w_state = FETCH_REQ;
                    end
                end
            end

            FETCH_FLUSH: begin
                if (w_redirect && w_target_bad) begin
                    w_exc   = 1'b1;
                    w_state = FETCH_IDLE;
                end else begin
                    if (w_redirect) begin
                        w_pc = w_target;
                    end
                    if (mem_read_ack) begin
                        w_state = FETCH_REQ;
                    end
                end
            end

            default: w_state = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_state  <= FETCH_IDLE;
            r_pc     <= RESET_PC;
            r_req    <= 1'b0;
            r_addr   <= '0;
            r_en     <= 1'b0;
            r_ir     <= '0;
            r_pc_out <= '0;
            r_exc    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_pc     <= w_pc;
            r_req    <= w_req;
            r_addr   <= w_addr;
            r_en     <= w_en;
            r_ir     <= w_ir;
            r_pc_out <= w_pc_out;
            r_exc    <= w_exc;
        end
    end

    assign mem_read_req              = r_req;
    assign mem_addr                  = r_addr;
    assign enable_out                = r_en;
    assign IR_out                    = r_ir;
    assign PC_out                    = r_pc_out;
    assign exception_addr_misaligned = r_exc;
    assign busy                      = (r_state != FETCH_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rv2t_instruction_fetch.sv
// ============================================================================
// Module  : tb_rv2t_instruction_fetch
// Brief   : Directed self-checking bench for the instruction fetch stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rv2t_instruction_fetch;

    logic        clk = 1'b0;
    logic        sync_reset = 1'b1;
    logic        fetch_init = 1'b0;
    logic [31:0] start_addr = '0;
    logic        fetch_enable = 1'b0;
    logic        jump_req = 1'b0;
    logic [31:0] jump_addr = '0;
    logic        mem_read_req;
    logic [31:0] mem_addr;
    logic        mem_read_ack = 1'b0;
    logic [31:0] mem_data = '0;
    logic        enable_out;
    logic [31:0] IR_out;
    logic [31:0] PC_out;
    logic        exception_addr_misaligned;
    logic        busy;

    int checks = 0;
    int errors = 0;

    rv2t_instruction_fetch #(
        .PC_WIDTH (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk                       (clk),
        .sync_reset                (sync_reset),
        .fetch_init                (fetch_init),
        .start_addr                (start_addr),
        .fetch_enable              (fetch_enable),
        .jump_req                  (jump_req),
        .jump_addr                 (jump_addr),
        .mem_read_req              (mem_read_req),
        .mem_addr                  (mem_addr),
        .mem_read_ack              (mem_read_ack),
        .mem_data                  (mem_data),
        .enable_out                (enable_out),
        .IR_out                    (IR_out),
        .PC_out                    (PC_out),
        .exception_addr_misaligned (exception_addr_misaligned),
        .busy                      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},  {31'b0, mem_read_req}, 32'h0);
        check({tag, "_addr"}, mem_addr, 32'h0);
        check({tag, "_en"},   {31'b0, enable_out}, 32'h0);
        check({tag, "_ir"},   IR_out, 32'h0);
        check({tag, "_pc"},   PC_out, 32'h0);
        check({tag, "_exc"},  {31'b0, exception_addr_misaligned}, 32'h0);
        check({tag, "_busy"}, {31'b0, busy}, 32'h0);
    endtask

    initial begin
        int req_seen;

        // Reset state
        tick();
        tick();
        check_all_zero("reset");

        // Test 1: sequential fetch from 0x80 with ack latency 1
        sync_reset   = 1'b0;
        fetch_init   = 1'b1;
        start_addr   = 32'h80;
        fetch_enable = 1'b1;
        tick();
        fetch_init = 1'b0;
        check("t1_busy", {31'b0, busy}, 32'h1);
        check("t1_noreq_yet", {31'b0, mem_read_req}, 32'h0);
        tick();
        check("t1_req0", {31'b0, mem_read_req}, 32'h1);
        check("t1_addr0", mem_addr, 32'h80);
        mem_read_ack = 1'b1; mem_data = 32'h1111_0080;
        tick();
        check("t1_en0", {31'b0, enable_out}, 32'h1);
        check("t1_ir0", IR_out, 32'h1111_0080);
        check("t1_pc0", PC_out, 32'h80);
        check("t1_req1", {31'b0, mem_read_req}, 32'h1);
        check("t1_addr1", mem_addr, 32'h84);
        mem_read_ack = 1'b0;
        tick();
        check("t1_req_pulse", {31'b0, mem_read_req}, 32'h0);
        check("t1_en_pulse", {31'b0, enable_out}, 32'h0);
        mem_read_ack = 1'b1; mem_data = 32'h2222_0084;
        tick();
        check("t1_ir1", IR_out, 32'h2222_0084);
        check("t1_pc1", PC_out, 32'h84);
        check("t1_addr2", mem_addr, 32'h88);
        mem_read_ack = 1'b0;
        tick();
        mem_read_ack = 1'b1; mem_data = 32'h3333_0088;
        tick();
        check("t1_en2", {31'b0, enable_out}, 32'h1);
        check("t1_ir2", IR_out, 32'h3333_0088);
        check("t1_pc2", PC_out, 32'h88);
        mem_read_ack = 1'b0;
        tick();

        // Reset while waiting on 0x8C, then a stray ack
        sync_reset = 1'b1;
        tick();
        check_all_zero("rst_wait");
        sync_reset   = 1'b0;
        mem_read_ack = 1'b1; mem_data = 32'hBAD0_BAD0;
        tick();
        check("stray_en", {31'b0, enable_out}, 32'h0);
        check("stray_busy", {31'b0, busy}, 32'h0);
        mem_read_ack = 1'b0;

        // Test 2: stall for 5 cycles after the first ack
        fetch_init = 1'b1; start_addr = 32'h80;
        tick();
        fetch_init = 1'b0;
        tick();
        check("t2_addr0", mem_addr, 32'h80);
        mem_read_ack = 1'b1; mem_data = 32'hAAAA_0080; fetch_enable = 1'b0;
        tick();
        check("t2_en0", {31'b0, enable_out}, 32'h1);
        check("t2_pc0", PC_out, 32'h80);
        mem_read_ack = 1'b0;
        req_seen = (mem_read_req === 1'b1) ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (mem_read_req !== 1'b0) req_seen++;
        end
        check("t2_stall_noreq", req_seen, 32'd0);
        fetch_enable = 1'b1;
        tick();
        check("t2_resume_req", {31'b0, mem_read_req}, 32'h1);
        check("t2_resume_addr", mem_addr, 32'h84);

        // Test 3: jump while waiting, stale ack 3 cycles later
        jump_req = 1'b1; jump_addr = 32'h200;
        tick();
        jump_req = 1'b0;
        check("t3_flush_noreq", {31'b0, mem_read_req}, 32'h0);
        check("t3_flush_busy", {31'b0, busy}, 32'h1);
        tick();
        tick();
        mem_read_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
        tick();
        mem_read_ack = 1'b0;
        check("t3_stale_en", {31'b0, enable_out}, 32'h0);
        check("t3_stale_ir", IR_out, 32'hAAAA_0080);
        tick();
        check("t3_req", {31'b0, mem_read_req}, 32'h1);
        check("t3_addr", mem_addr, 32'h200);
        check("t3_no_en", {31'b0, enable_out}, 32'h0);

        // Test 4: jump and ack in the same cycle
        jump_req = 1'b1; jump_addr = 32'h300;
        mem_read_ack = 1'b1; mem_data = 32'h5555_5555;
        tick();
        jump_req = 1'b0; mem_read_ack = 1'b0;
        check("t4_drop_en", {31'b0, enable_out}, 32'h0);
        check("t4_drop_req", {31'b0, mem_read_req}, 32'h0);
        tick();
        check("t4_req", {31'b0, mem_read_req}, 32'h1);
        check("t4_addr", mem_addr, 32'h300);
        check("t4_no_en", {31'b0, enable_out}, 32'h0);

        // Test 5: misaligned jump while a read is in flight
        jump_req = 1'b1; jump_addr = 32'h102;
        tick();
        jump_req = 1'b0;
        check("t5_exc", {31'b0, exception_addr_misaligned}, 32'h1);
        check("t5_busy", {31'b0, busy}, 32'h0);
        check("t5_noreq", {31'b0, mem_read_req}, 32'h0);
        mem_read_ack = 1'b1; mem_data = 32'h7777_7777;
        tick();
        mem_read_ack = 1'b0;
        check("t5_exc_pulse", {31'b0, exception_addr_misaligned}, 32'h0);
        check("t5_drop_en", {31'b0, enable_out}, 32'h0);
        req_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_read_req !== 1'b0) req_seen++;
        end
        check("t5_idle_noreq", req_seen, 32'd0);

        // Test 6: PC wrap and reset mid-wait
        fetch_init = 1'b1; start_addr = 32'hFFFF_FFFC;
        tick();
        fetch_init = 1'b0;
        tick();
        check("t6_addr_top", mem_addr, 32'hFFFF_FFFC);
        mem_read_ack = 1'b1; mem_data = 32'h6666_6666;
        tick();
        mem_read_ack = 1'b0;
        check("t6_pc_top", PC_out, 32'hFFFF_FFFC);
        check("t6_ir_top", IR_out, 32'h6666_6666);
        check("t6_wrap_addr", mem_addr, 32'h0);
        check("t6_wrap_req", {31'b0, mem_read_req}, 32'h1);
        tick();
        sync_reset = 1'b1;
        tick();
        check_all_zero("t6_rst");
        sync_reset   = 1'b0;
        mem_read_ack = 1'b1; mem_data = 32'h9999_9999;
        tick();
        mem_read_ack = 1'b0;
        check("t6_late_en", {31'b0, enable_out}, 32'h0);
        check("t6_late_ir", IR_out, 32'h0);
        check("t6_late_busy", {31'b0, busy}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
